// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED show scheduler: FSM states,
// requester indices and the priority picker used by arbitration.
package led_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int REQ_BEAT    = 0;
    localparam int REQ_CHASE   = 1;
    localparam int REQ_WIN     = 2;
    localparam int REQ_JACKPOT = 3;

    localparam int STEP_W = 6;

    // Highest-index set bit wins, which is exactly the fixed priority order.
    function automatic logic [3:0] prio_pick(input logic [3:0] r);
        logic [3:0] pick;
        pick = '0;
        for (int i = 0; i < 4; i++) begin
            if (r[i]) pick = 4'b0001 << i;
        end
        return pick;
    endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Step-tick prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick
// in the cycle the count wraps. clr restarts the count for a new grant.
module led_tick_prescaler #(
    parameter int TICK_DIV = 4194304
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Not gated by clr: a grant switch decided on a wrap cycle still shows
    // that wrap, and gating here would loop back through the hold check.
    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/led_show_scheduler.sv
// Fixed-priority owner scheduler for the 16-LED bank with minimum hold,
// one-shot shows and a shared step tick. Define LED_SCHED_RR_EN to make
// chase and beat alternate every MIN_HOLD ticks while both are requesting.
module led_show_scheduler
    import led_sched_pkg::*;
#(
    parameter int TICK_DIV      = 4194304,
    parameter int ONESHOT_STEPS = 32,
    parameter int MIN_HOLD      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    output logic [3:0]        grant,
    output logic              step_tick,
    output logic [STEP_W-1:0] step,
    output logic [3:0]        ack,
    output logic              busy
);

    localparam logic [STEP_W-1:0] HOLD_MAX   = '1;
    localparam logic [STEP_W-1:0] MIN_HOLD_L = STEP_W'(MIN_HOLD);
    localparam logic [STEP_W-1:0] OS_LAST    = STEP_W'(ONESHOT_STEPS - 1);

    state_e            state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [3:0]        ack_q, ack_d;
    logic [3:2]        req_q, rise, os_run, pend_q, pend_d, pend_eff;
    logic [STEP_W-1:0] step_q, step_d, hold_q, hold_d, hold_eff;
    logic [3:0]        win, load_grant;
    logic              tick, hold_ok, owner_fell, rr_swap;
    logic              load, finish, drop;

    led_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (state_q == RUN),
        .tick (tick)
    );

    // An edge on the one-shot that is already running is not latched.
    assign rise     = req[3:2] & ~req_q;
    assign os_run   = (state_q == RUN) ? grant_q[3:2] : 2'b00;
    assign pend_eff = pend_q | (rise & ~os_run);
    assign win      = prio_pick({pend_eff, req[REQ_CHASE], req[REQ_BEAT]});

    // Hold counts the tick landing this cycle, so a switch due on the
    // MIN_HOLD-th tick happens on that tick's edge.
    assign hold_eff   = (tick && hold_q != HOLD_MAX) ? hold_q + 1'b1 : hold_q;
    assign hold_ok    = hold_eff >= MIN_HOLD_L;
    assign owner_fell = !(req[REQ_CHASE] && grant_q[REQ_CHASE]) &&
                        !(req[REQ_BEAT]  && grant_q[REQ_BEAT]);

`ifdef LED_SCHED_RR_EN
    assign rr_swap = grant_q[REQ_CHASE] && req[REQ_BEAT] && req[REQ_CHASE] &&
                     (pend_eff == 2'b00) && hold_ok;
`else
    assign rr_swap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_grant = '0;
        finish     = 1'b0;
        drop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|win) begin
                    load       = 1'b1;
                    load_grant = win;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (grant_q[REQ_WIN] || grant_q[REQ_JACKPOT]) begin
                    if (grant_q[REQ_WIN] && pend_eff[REQ_JACKPOT]) begin
                        load       = 1'b1;
                        load_grant = win;
                    end else if (tick && step_q == OS_LAST) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end
                end else if (win > grant_q && hold_ok) begin
                    load       = 1'b1;
                    load_grant = win;
                end else if (rr_swap) begin
                    load       = 1'b1;
                    load_grant = 4'b0001 << REQ_BEAT;
                end else if (owner_fell) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        step_d  = step_q;
        hold_d  = hold_q;
        ack_d   = '0;
        pend_d  = pend_eff;
        if (load) begin
            grant_d = load_grant;
            step_d  = '0;
            hold_d  = '0;
            pend_d  = pend_eff & ~load_grant[3:2];
        end else if (finish) begin
            grant_d = '0;
            ack_d   = grant_q;
            step_d  = step_q + 1'b1;
        end else if (drop || state_q == DONE) begin
            grant_d = '0;
        end else if (tick) begin
            step_d = step_q + 1'b1;
            hold_d = hold_eff;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            ack_q   <= '0;
            req_q   <= '0;
            pend_q  <= '0;
            step_q  <= '0;
            hold_q  <= '0;
        end else begin
            grant_q <= grant_d;
            ack_q   <= ack_d;
            req_q   <= req[3:2];
            pend_q  <= pend_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        grant     = grant_q;
        step      = step_q;
        ack       = ack_q;
        busy      = |grant_q;
        step_tick = tick;
    end

endmodule

// File: tb/tb_led_show_scheduler.sv
// Bench for led_show_scheduler: directed vector table, reset abort sequence
// and random requests checked every cycle against an owner-level model.
module tb_led_show_scheduler;

    localparam int TD = 4;
    localparam int OS = 3;
    localparam int MH = 2;
`ifdef LED_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant, ack;
    logic       step_tick, busy;
    logic [5:0] step;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    led_show_scheduler #(.TICK_DIV(TD), .ONESHOT_STEPS(OS), .MIN_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .step_tick(step_tick),
        .step(step), .ack(ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got {grant,step,tick,ack,busy}=%h expected %h",
                     name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] dut_pk();
        return {grant, step, step_tick, ack, busy};
    endfunction

    // Model: owner index (-1 none), mode 0 idle / 1 running / 2 done,
    // cycles since grant, ticks as step and hold counts.
    int m_st, m_own, m_step, m_hold, m_cyc, m_ack;
    bit m_pend[4];
    bit m_prev[4];
    logic [15:0] mdl_pk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_own = -1; m_step = 0; m_hold = 0; m_cyc = 0; m_ack = -1;
            for (int n = 0; n < 4; n++) begin m_pend[n] = 0; m_prev[n] = 0; end
        end else begin : mdl
            bit tk;
            bit pe[4];
            int best, held, go;
            tk = (m_st == 1) && (m_cyc % TD == TD - 1);
            pe[0] = 0; pe[1] = 0;
            for (int n = 2; n < 4; n++)
                pe[n] = m_pend[n] || (req[n] && !m_prev[n] && !(m_st == 1 && m_own == n));
            best = pe[3] ? 3 : pe[2] ? 2 : req[1] ? 1 : req[0] ? 0 : -1;
            held = m_hold + (tk ? 1 : 0);
            if (held > 63) held = 63;
            go = -1;
            m_ack = -1;
            if (m_st == 0) begin
                go = best;
            end else if (m_st == 2) begin
                m_st = 0;
            end else if (m_own < 2) begin
                if (best > m_own && held >= MH) go = best;
                else if (RR && m_own == 1 && req[0] && req[1] && !pe[2] && !pe[3] && held >= MH) go = 0;
                else if (!req[m_own]) begin m_st = 0; m_own = -1; end
                else begin
                    if (tk) begin m_step = (m_step + 1) % 64; m_hold = held; end
                    m_cyc++;
                end
            end else begin
                if (m_own == 2 && pe[3]) go = 3;
                else if (tk && m_step + 1 == OS) begin
                    m_st = 2; m_ack = m_own; m_own = -1; m_step = m_step + 1;
                end else begin
                    if (tk) begin m_step = (m_step + 1) % 64; m_hold = held; end
                    m_cyc++;
                end
            end
            if (go >= 0) begin
                m_own = go; m_st = 1; m_step = 0; m_hold = 0; m_cyc = 0; pe[go] = 0;
            end
            for (int n = 0; n < 4; n++) begin m_pend[n] = pe[n]; m_prev[n] = req[n]; end
        end
    end

    always_comb begin
        logic [3:0] mg, ma;
        mg = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
        ma = (m_ack >= 0) ? (4'b0001 << m_ack) : 4'b0000;
        mdl_pk = {mg, 6'(m_step), (m_st == 1) && (m_cyc % TD == TD - 1), ma, m_own >= 0};
    end

    always @(negedge clk) if (chk_en) chk("model", dut_pk(), mdl_pk);

    typedef struct {
        logic [3:0] req;
        int         n;
        logic [3:0] g;
        logic [5:0] s;
        logic       t;
        logic [3:0] a;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [3:0] r, input int n, input logic [3:0] g,
                       input logic [5:0] s, input logic t, input logic [3:0] a);
        vec_t v;
        v.req = r; v.n = n; v.g = g; v.s = s; v.t = t; v.a = a;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", dut_pk(), 16'h0000);
        rst = 1'b0;
        chk_en = 1'b1;

        // continuous beat: tick cadence, step count, drop
        add(4'b0001, 1,  4'b0001, 0, 0, 4'b0000);
        add(4'b0001, 3,  4'b0001, 0, 1, 4'b0000);
        add(4'b0001, 1,  4'b0001, 1, 0, 4'b0000);
        add(4'b0001, 4,  4'b0001, 2, 0, 4'b0000);
        add(4'b0000, 1,  4'b0000, 2, 0, 4'b0000);
        // win pulse waits for hold, runs 3 ticks, beat re-granted 2 cycles after ack
        add(4'b0001, 1,  4'b0001, 0, 0, 4'b0000);
        add(4'b0101, 1,  4'b0001, 0, 0, 4'b0000);
        add(4'b0001, 6,  4'b0001, 1, 1, 4'b0000);
        add(4'b0001, 1,  4'b0100, 0, 0, 4'b0000);
        add(4'b0001, 12, 4'b0000, 3, 0, 4'b0100);
        add(4'b0001, 1,  4'b0000, 3, 0, 4'b0000);
        add(4'b0001, 1,  4'b0001, 0, 0, 4'b0000);
        // jackpot preempts a running win, win is dropped
        add(4'b0000, 1,  4'b0000, 0, 0, 4'b0000);
        add(4'b0100, 1,  4'b0100, 0, 0, 4'b0000);
        add(4'b0100, 4,  4'b0100, 1, 0, 4'b0000);
        add(4'b1100, 1,  4'b1000, 0, 0, 4'b0000);
        add(4'b0000, 12, 4'b0000, 3, 0, 4'b1000);
        add(4'b0000, 1,  4'b0000, 3, 0, 4'b0000);
        // simultaneous edges: jackpot then win
        add(4'b1100, 1,  4'b1000, 0, 0, 4'b0000);
        add(4'b0000, 12, 4'b0000, 3, 0, 4'b1000);
        add(4'b0000, 1,  4'b0000, 3, 0, 4'b0000);
        add(4'b0000, 1,  4'b0100, 0, 0, 4'b0000);
        add(4'b0000, 12, 4'b0000, 3, 0, 4'b0100);
        add(4'b0000, 2,  4'b0000, 3, 0, 4'b0000);
        // chase and beat together
        add(4'b0011, 1,  4'b0010, 0, 0, 4'b0000);
        if (RR) begin
            add(4'b0011, 8, 4'b0001, 0, 0, 4'b0000);
            add(4'b0011, 8, 4'b0010, 0, 0, 4'b0000);
            add(4'b0000, 1, 4'b0000, 0, 0, 4'b0000);
        end else begin
            add(4'b0011, 8, 4'b0010, 2, 0, 4'b0000);
            add(4'b0011, 8, 4'b0010, 4, 0, 4'b0000);
            add(4'b0000, 1, 4'b0000, 4, 0, 4'b0000);
        end

        foreach (tbl[i]) begin
            req = tbl[i].req;
            repeat (tbl[i].n) @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d", i), dut_pk(),
                {tbl[i].g, tbl[i].s, tbl[i].t, tbl[i].a, |tbl[i].g});
        end

        // reset in the middle of a jackpot show
        req = 4'b1000;
        @(posedge clk); @(negedge clk);
        chk("jackpot_start", dut_pk(), {4'b1000, 6'd0, 1'b0, 4'b0000, 1'b1});
        req = 4'b0000;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("jackpot_step2", dut_pk(), {4'b1000, 6'd2, 1'b0, 4'b0000, 1'b1});
        rst = 1'b1;
        #1;
        chk("async_reset", dut_pk(), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("idle_after_reset", dut_pk(), 16'h0000);

        // random requests against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 6) req[0] = ~req[0];
            if ($urandom_range(0, 99) < 5) req[1] = ~req[1];
            if ($urandom_range(0, 99) < 4) req[2] = ~req[2];
            if ($urandom_range(0, 99) < 2) req[3] = ~req[3];
            rst = (c == 2000);
            @(negedge clk);
        end
        rst = 1'b0;
        req = 4'b0000;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/led_show_scheduler.md
Name: led_show_scheduler

Overview:
- Sequences and shares the 16-LED bank between pattern requesters: beat flash, idle chase, win show and jackpot show.
- Arbitrates the requests by fixed priority with a minimum hold time.
- Generates the common step tick and step index that the LED pattern datapath consumes.
- Sits between the game FSM / beat generator and the LED pattern datapath; replaces direct state decoding inside the LED driver.

Parameters:
- TICK_DIV, 4194304, clk cycles per step tick (2^22 gives ~42 ms at 100 MHz); legal range 2..2^26.
- ONESHOT_STEPS, 32, step ticks a one-shot show (win/jackpot) runs before completing; legal range 1..63.
- MIN_HOLD, 4, minimum step ticks a continuous grant is held before it can be preempted; legal range 1..63.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  4  request lines: [0] beat flash (level), [1] idle chase (level), [2] win show (rising-edge one-shot), [3] jackpot show (rising-edge one-shot)
- grant  out  4  one-hot current owner; 0 = nobody
- step_tick  out  1  one-cycle pulse every TICK_DIV cycles while busy
- step  out  6  step index of the current grant, +1 per step_tick, wraps 63->0
- ack  out  4  one-cycle pulse on completion of a one-shot; only bits [3:2] are ever set
- busy  out  1  grant != 0

Behaviour:
- Reset (async): grant=0, step=0, step_tick=0, ack=0, busy=0, prescaler=0, pend[3:2]=0, hold counter=0, FSM=IDLE.
- One-shot latching:
  - A rising edge of req[2] or req[3] sets pend[n]; edges are detected against a registered copy of req.
  - pend[n] clears in the cycle grant[n] is issued.
  - An edge on the currently running one-shot is ignored.
- Priority is fixed: pend[3] > pend[2] > req[1] > req[0].
- FSM states IDLE, RUN, DONE.
- IDLE:
  - When any request is active, grant the winner on the next edge and go to RUN.
  - On grant: step=0, prescaler=0, hold=0.
- RUN, prescaler:
  - Prescaler counts 0..TICK_DIV-1.
  - step_tick is asserted in the cycle the prescaler wraps; step and hold increment on that same edge.
  - First tick occurs TICK_DIV cycles after grant.
- RUN with a continuous owner (0 or 1):
  - If the owning req falls, grant=0 next cycle and return to IDLE. There is no drain.
  - A higher-priority request preempts only when hold >= MIN_HOLD. The new grant switches directly without passing IDLE, and step/prescaler/hold reset.
  - Hold saturates at 63.
- RUN with a one-shot owner (2 or 3):
  - Req level is ignored.
  - Jackpot preempts win immediately, regardless of hold. The interrupted win is dropped and no ack[2] is issued.
  - Win never preempts jackpot; a win edge during jackpot is held in pend[2].
  - On the ONESHOT_STEPS-th tick, go to DONE.
- DONE (exactly 1 cycle):
  - ack[n]=1, grant=0, step held.
  - Next cycle goes to IDLE.
  - Re-arbitration therefore costs exactly 2 cycles after a one-shot ends.
- Simultaneous events:
  - Edge on req[3] and req[2] in the same cycle: both pend bits set; jackpot served first, win after.
  - Owner's req falls in the same cycle a preemption is allowed: the preempt wins (direct switch).
- Reset mid-operation aborts everything: pends are lost and no ack is issued.
- step_tick is never asserted while grant=0.

Optional Feature:
- Macro LED_SCHED_RR_EN.
- Defined:
  - While req[0] and req[1] are both high and no pend bit is set, ownership alternates between them.
  - The switch happens every MIN_HOLD ticks, starting with req[1].
  - Each switch resets step to 0.
- Undefined: req[1] strictly wins over req[0]; req[0] is served only when req[1] is low.

Decomposition:
- Package led_sched_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - requester index constants REQ_BEAT=0, REQ_CHASE=1, REQ_WIN=2, REQ_JACKPOT=3;
  - width constant STEP_W=6.
- Sub-module led_tick_prescaler: parameter TICK_DIV; inputs clk, rst, clr, en; output tick.
- Arbitration and FSM stay in the top.

Test Plan (TICK_DIV=4, ONESHOT_STEPS=3, MIN_HOLD=2 for sim):
- req=0001 held -> grant=0001 one cycle later; step_tick every 4 cycles; step 0,1,2,...; drop req -> grant=0 next cycle.
- Win pulse of 1 cycle while req=0001 with hold=0 -> pend[2] stays set until hold=2, then grant=0100 and step=0. After 3 ticks (12 cycles): ack=0100 for 1 cycle, then grant=0001 two cycles later.
- Win running at step 1, jackpot edge -> grant=1000 next cycle; no ack[2] ever; ack=1000 after 3 ticks.
- Simultaneous req[3] and req[2] edges, nothing else pending:
  - jackpot runs first and ack=1000 pulses;
  - win is granted 2 cycles later and ack=0100 pulses after its 3 ticks.
- Assert rst mid-jackpot at step 2 -> all outputs 0 immediately (async); no ack; after release with req=0 the block stays IDLE.
- LED_SCHED_RR_EN defined, req=0011 held -> grant toggles 0010/0001 every 2 ticks (8 cycles), step resetting to 0 at each switch. Undefined -> grant stays 0010.
